// File: rtl/vga_pkg.sv
// Shared timing constants, total-length helper and test-bar colour table for vga_timing_gen.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_axis_t;

    localparam vga_axis_t MODE_640X480_H   = '{32'd640,  32'd16, 32'd96,  32'd48};
    localparam vga_axis_t MODE_640X480_V   = '{32'd480,  32'd10, 32'd2,   32'd33};
    localparam vga_axis_t MODE_800X600_H   = '{32'd800,  32'd40, 32'd128, 32'd88};
    localparam vga_axis_t MODE_800X600_V   = '{32'd600,  32'd1,  32'd4,   32'd23};
    localparam vga_axis_t MODE_1280X1024_H = '{32'd1280, 32'd48, 32'd112, 32'd248};
    localparam vga_axis_t MODE_1280X1024_V = '{32'd1024, 32'd1,  32'd3,   32'd38};

    // Bar colours as {R,G,B}; bar 0 (leftmost) is in the low bits.
    localparam logic [23:0] TESTBAR_RGB = {3'b111, 3'b110, 3'b101, 3'b100,
                                           3'b011, 3'b010, 3'b001, 3'b000};

    function automatic int unsigned vga_total(input int unsigned active, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic logic [2:0] testbar_rgb(input logic [2:0] idx);
        return TESTBAR_RGB[5'(idx) * 5'd3 +: 3];
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-fetch port of vga_timing_gen: request coordinates out, colour back LEAD cycles later.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned COLOR_W = 4
);
    logic                   req_valid;
    logic [CNT_W-1:0]       req_x;
    logic [CNT_W-1:0]       req_y;
    logic [3*COLOR_W-1:0]   pixel_color;

    modport master (output req_valid, output req_x, output req_y, input pixel_color);
    modport slave  (input req_valid, input req_x, input req_y, output pixel_color);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear; DEPTH 0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per cycle; clear drops any in-flight contents.
        always_ff @(posedge clk) begin
            if (clr) begin
                for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with LEAD-cycle pixel-fetch lookahead.
// Optional colour-bar test pattern: define VGA_TIMING_TESTPAT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FRONT  = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BACK   = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FRONT  = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BACK   = 38,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned LEAD     = 1
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
`ifdef VGA_TIMING_TESTPAT_EN
    input  logic                 test_mode,
`endif
    vga_timing_gen_if.master     fetch,
    output logic                 frame_start,
    output logic                 line_start,
    output logic [COLOR_W-1:0]   VGA_BUS_R,
    output logic [COLOR_W-1:0]   VGA_BUS_G,
    output logic [COLOR_W-1:0]   VGA_BUS_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_DE
);
    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int unsigned PIPE_W = 3 + CNT_W;
`else
    localparam int unsigned PIPE_W = 3;
`endif

    logic [CNT_W-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic                 de_s, hs_s, vs_s;
    logic [PIPE_W-1:0]    pipe_in_s, pipe_out_s;
    logic                 de_dly_s, hs_dly_s, vs_dly_s;
    logic [3*COLOR_W-1:0] color_d, color_q;
    logic                 de_q, hs_q, vs_q;

    // Next raster position: h wraps every line, v advances only on that wrap.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    // Raster counters.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign de_s = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign hs_s = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs_s = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    assign fetch.req_valid = de_s;
    assign fetch.req_x     = h_cnt_q;
    assign fetch.req_y     = v_cnt_q;
    assign frame_start     = !reset && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign line_start      = !reset && (h_cnt_q == '0);

`ifdef VGA_TIMING_TESTPAT_EN
    logic [CNT_W-1:0]   x_dly_s;
    logic [CNT_W+2:0]   bar_prod_s;
    logic [2:0]         bar_idx_s, bar_rgb_s;
    logic [3*COLOR_W-1:0] bar_color_s;

    assign pipe_in_s   = {h_cnt_q, de_s, hs_s, vs_s};
    assign x_dly_s     = pipe_out_s[PIPE_W-1:3];
    assign bar_prod_s  = {x_dly_s, 3'b000};
    assign bar_idx_s   = 3'(bar_prod_s / (CNT_W+3)'(H_ACTIVE));
    assign bar_rgb_s   = testbar_rgb(bar_idx_s);
    // pixel_color order is {B,G,R}; the bar table is {R,G,B}.
    assign bar_color_s = {{COLOR_W{bar_rgb_s[0]}}, {COLOR_W{bar_rgb_s[1]}}, {COLOR_W{bar_rgb_s[2]}}};
`else
    assign pipe_in_s   = {de_s, hs_s, vs_s};
`endif

    vga_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (LEAD)
    ) u_delay (
        .clk (pixel_clk),
        .clr (reset),
        .d   (pipe_in_s),
        .q   (pipe_out_s)
    );

    assign de_dly_s = pipe_out_s[2];
    assign hs_dly_s = pipe_out_s[1];
    assign vs_dly_s = pipe_out_s[0];

    // Colour source select; blanked outside the active area.
    always_comb begin
        color_d = '0;
        if (de_dly_s) begin
`ifdef VGA_TIMING_TESTPAT_EN
            if (test_mode) begin
                color_d = bar_color_s;
            end else begin
                color_d = fetch.pixel_color;
            end
`else
            color_d = fetch.pixel_color;
`endif
        end else begin
            color_d = '0;
        end
    end

    // Output register with sync polarity applied.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            color_q <= '0;
        end else begin
            de_q    <= de_dly_s;
            hs_q    <= hs_dly_s ~^ HS_POL;
            vs_q    <= vs_dly_s ~^ VS_POL;
            color_q <= color_d;
        end
    end

    assign VGA_DE    = de_q;
    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_BUS_R = color_q[COLOR_W-1:0];
    assign VGA_BUS_G = color_q[2*COLOR_W-1:COLOR_W];
    assign VGA_BUS_B = color_q[3*COLOR_W-1:2*COLOR_W];

endmodule
